// File: rtl/glb_core_bank_wr_arbiter_if.sv
// glb_core_bank_wr_arbiter_if: stream/processor write inputs and bank write outputs of the arbiter.
interface glb_core_bank_wr_arbiter_if #(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 22,
    parameter int BANK_ADDR_WIDTH = 17
);
    localparam int SW = DATA_WIDTH / 8;
    logic                       strm_wr_en;
    logic [SW-1:0]              strm_wr_strb;
    logic [DATA_WIDTH-1:0]      strm_wr_data;
    logic [ADDR_WIDTH-1:0]      strm_wr_addr;
    logic                       proc_wr_en;
    logic [SW-1:0]              proc_wr_strb;
    logic [DATA_WIDTH-1:0]      proc_wr_data;
    logic [ADDR_WIDTH-1:0]      proc_wr_addr;
    logic [1:0]                 bank_wr_en;
    logic [BANK_ADDR_WIDTH-4:0] bank_wr_addr;
    logic [DATA_WIDTH-1:0]      bank_wr_data;
    logic [DATA_WIDTH-1:0]      bank_wr_mask;

    modport master (
        output strm_wr_en, strm_wr_strb, strm_wr_data, strm_wr_addr,
        output proc_wr_en, proc_wr_strb, proc_wr_data, proc_wr_addr,
        input  bank_wr_en, bank_wr_addr, bank_wr_data, bank_wr_mask
    );
    modport slave (
        input  strm_wr_en, strm_wr_strb, strm_wr_data, strm_wr_addr,
        input  proc_wr_en, proc_wr_strb, proc_wr_data, proc_wr_addr,
        output bank_wr_en, bank_wr_addr, bank_wr_data, bank_wr_mask
    );
endinterface

// File: rtl/glb_core_bank_wr_arbiter.sv
// glb_core_bank_wr_arbiter: proc-priority bank write arbiter with a coalescing stream write FIFO.
module glb_core_bank_wr_arbiter #(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 22,
    parameter int BANK_ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clk_en,
    input  logic                               overflow_clr,
    glb_core_bank_wr_arbiter_if.slave          bus,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    strm_fifo_cnt,
    output logic                               strm_overflow
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int WW = ADDR_WIDTH - 3;
    localparam int BW = BANK_ADDR_WIDTH - 3;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [WW-1:0]         addr_mem_q [FIFO_DEPTH];
    logic [WW-1:0]         addr_mem_d [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_d [FIFO_DEPTH];
    logic [SW-1:0]         strb_mem_q [FIFO_DEPTH];
    logic [SW-1:0]         strb_mem_d [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, tail;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [1:0]            en_q, en_d;
    logic [BW-1:0]         addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d, mask_q, mask_d;
    logic                  pop, push, coalesce, drop, act;
    logic [WW-1:0]         strm_waddr;
    logic [BW:0]           sel_waddr;
    logic [SW-1:0]         sel_strb;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{bus.proc_wr_addr[ADDR_WIDTH-1:BANK_ADDR_WIDTH+1],
                                bus.proc_wr_addr[2:0], bus.strm_wr_addr[2:0]};

    function automatic logic [DATA_WIDTH-1:0] expand(input logic [SW-1:0] s);
        logic [DATA_WIDTH-1:0] m;
        for (int i = 0; i < SW; i++) m[8*i +: 8] = {8{s[i]}};
        return m;
    endfunction

    always_comb begin
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        strb_mem_d = strb_mem_q;
        strm_waddr = bus.strm_wr_addr[ADDR_WIDTH-1:3];
        tail       = wr_ptr_q - 1'b1;
        pop        = (cnt_q != '0) && !bus.proc_wr_en;
        // The tail may only be merged into while it is guaranteed to stay in the FIFO.
        coalesce   = bus.strm_wr_en && (cnt_q != '0) && (strm_waddr == addr_mem_q[tail])
                     && !(pop && cnt_q == CW'(1));
        push       = bus.strm_wr_en && !coalesce && ((cnt_q != CW'(FIFO_DEPTH)) || pop);
        drop       = bus.strm_wr_en && !coalesce && !push;
        if (coalesce) begin
            for (int i = 0; i < SW; i++)
                if (bus.strm_wr_strb[i]) data_mem_d[tail][8*i +: 8] = bus.strm_wr_data[8*i +: 8];
            strb_mem_d[tail] = strb_mem_q[tail] | bus.strm_wr_strb;
        end
        if (push) begin
            addr_mem_d[wr_ptr_q] = strm_waddr;
            data_mem_d[wr_ptr_q] = bus.strm_wr_data;
            strb_mem_d[wr_ptr_q] = bus.strm_wr_strb;
        end
        wr_ptr_d  = wr_ptr_q + PW'(push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
        ovf_d     = drop || (ovf_q && !overflow_clr);
        act       = bus.proc_wr_en || pop;
        sel_waddr = bus.proc_wr_en ? bus.proc_wr_addr[BANK_ADDR_WIDTH:3] : addr_mem_q[rd_ptr_q][BW:0];
        sel_strb  = bus.proc_wr_en ? bus.proc_wr_strb : strb_mem_q[rd_ptr_q];
        en_d      = act ? {sel_waddr[BW], !sel_waddr[BW]} : 2'b00;
        addr_d    = act ? sel_waddr[BW-1:0] : '0;
        data_d    = !act ? '0 : bus.proc_wr_en ? bus.proc_wr_data : data_mem_q[rd_ptr_q];
        mask_d    = act ? expand(sel_strb) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_mem_q <= '{default: '0};
            data_mem_q <= '{default: '0};
            strb_mem_q <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            en_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            mask_q     <= '0;
        end else if (clk_en) begin
            addr_mem_q <= addr_mem_d;
            data_mem_q <= data_mem_d;
            strb_mem_q <= strb_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            en_q       <= en_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
        end
    end

    assign bus.bank_wr_en   = en_q;
    assign bus.bank_wr_addr = addr_q;
    assign bus.bank_wr_data = data_q;
    assign bus.bank_wr_mask = mask_q;
    assign strm_fifo_cnt    = cnt_q;
    assign strm_overflow    = ovf_q;
endmodule
